// File: rtl/ws2812b_pkg.sv
// Constants shared by the WS2812B frame path: colour byte order within an LED,
// the per-LED-step byte count and the frame sequencer state encoding.
package ws2812b_pkg;

  localparam int BYTE_G = 0;
  localparam int BYTE_R = 1;
  localparam int BYTE_B = 2;
  localparam int BYTES_PER_LED = 3;

  // Bytes fetched for one LED position across all parallel stripes.
  function automatic int led_step_bytes(input int stripecount);
    return BYTES_PER_LED * stripecount;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_HOLD,
    ST_DRAIN
  } seq_state_e;

endpackage

// File: rtl/ws2812b_ram_port_arbiter.sv
// Single RAM port mux: SPI writes always win; a read goes out only in a cycle
// without a write, and rd_valid marks the cycle its data sits on mem_rdata.
module ws2812b_ram_port_arbiter #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [7:0]            wr_data,
  output logic                  wr_ack,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_issue,
  output logic                  rd_valid,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [7:0]            mem_wdata
);

  logic rd_valid_q;

  always_comb begin
    wr_ack    = wr_req;
    mem_we    = wr_req;
    mem_wdata = wr_req ? wr_data : 8'h00;
    rd_issue  = rd_req && !wr_req;
    mem_addr  = '0;
    if (wr_req) begin
      mem_addr = wr_addr;
    end else if (rd_req) begin
      mem_addr = rd_addr;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_issue;
    end
  end

  assign rd_valid = rd_valid_q;

endmodule

// File: rtl/ws2812b_frame_sequencer.sv
// Per frame, fetches each LED step's colour bytes from the shared frame RAM and
// hands packed 24*STRIPECOUNT-bit words to the output module through a one-word buffer.
module ws2812b_frame_sequencer
  import ws2812b_pkg::*;
#(
  parameter int STRIPECOUNT = 3,
  parameter int LEDCOUNT    = 2,
  parameter int ADDR_WIDTH  = 14,
  parameter int BASE_ADDR   = 0
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       frame_start,
  input  logic                       wr_req,
  input  logic [ADDR_WIDTH-1:0]      wr_addr,
  input  logic [7:0]                 wr_data,
  output logic                       wr_ack,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  output logic                       mem_we,
  output logic [7:0]                 mem_wdata,
  input  logic [7:0]                 mem_rdata,
  output logic [24*STRIPECOUNT-1:0]  bitstream,
  output logic                       bitstream_available,
  input  logic                       bitstream_read,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       frame_overrun
);

  localparam int STEP = led_step_bytes(STRIPECOUNT);
  localparam int CW   = $clog2(STEP + 1);
  localparam int NW   = (LEDCOUNT > 1) ? $clog2(LEDCOUNT) : 1;
  localparam int WW   = 24 * STRIPECOUNT;

  localparam logic [CW-1:0]         STEP_C   = CW'(STEP);
  localparam logic [CW-1:0]         LAST_C   = CW'(STEP - 1);
  localparam logic [NW-1:0]         LAST_LED = NW'(LEDCOUNT - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE_A   = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] STEP_A   = ADDR_WIDTH'(STEP);

  seq_state_e            state_q, state_d;
  logic [NW-1:0]         led_q, led_d;
  logic [CW-1:0]         iss_q, iss_d;
  logic [CW-1:0]         cap_q, cap_d;
  logic [ADDR_WIDTH-1:0] led_base_q, led_base_d;
  logic [WW-1:0]         out_q, out_d;
  logic                  avail_q, avail_d;
  logic [7:0]            asm_q [STEP];
  logic [7:0]            asm_d [STEP];
  logic [WW-1:0]         word_d;

  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_issue;
  logic                  rd_valid;
  logic                  buf_free;
  logic                  last_cap;
  logic                  load;

  ws2812b_ram_port_arbiter #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_arb (
    .clk      (clk),
    .resetn   (resetn),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ack   (wr_ack),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_issue (rd_issue),
    .rd_valid (rd_valid),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_wdata(mem_wdata)
  );

  // Reads walk ascending addresses from the current LED step's base; wrap is modular.
  assign rd_req  = (state_q == ST_FETCH) && (iss_q != STEP_C);
  assign rd_addr = led_base_q + ADDR_WIDTH'(iss_q);

  // The word loaded on the last capture must include the byte arriving this cycle.
  for (genvar gi = 0; gi < STEP; gi++) begin : g_asm
    assign asm_d[gi] = (rd_valid && (cap_q == CW'(gi))) ? mem_rdata : asm_q[gi];
    assign word_d[24*(gi/3) + 8*(BYTE_B - (gi%3)) +: 8] = asm_d[gi];

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        asm_q[gi] <= 8'h00;
      end else begin
        asm_q[gi] <= asm_d[gi];
      end
    end
  end

  assign last_cap      = rd_valid && (cap_q == LAST_C);
  assign buf_free      = !avail_q || bitstream_read;
  assign frame_done    = (state_q == ST_DRAIN) && avail_q && bitstream_read;
  assign frame_overrun = frame_start && (state_q != ST_IDLE);
  assign busy          = (state_q != ST_IDLE) && !frame_done;

  always_comb begin
    state_d    = state_q;
    led_d      = led_q;
    iss_d      = iss_q;
    cap_d      = cap_q;
    led_base_d = led_base_q;
    out_d      = out_q;
    avail_d    = avail_q;
    load       = 1'b0;

    if (avail_q && bitstream_read) begin
      avail_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          state_d    = ST_FETCH;
          led_d      = '0;
          iss_d      = '0;
          cap_d      = '0;
          led_base_d = BASE_A;
        end
      end
      ST_FETCH: begin
        if (rd_issue) begin
          iss_d = iss_q + CW'(1);
        end
        if (rd_valid) begin
          cap_d = cap_q + CW'(1);
        end
        if (last_cap) begin
          if (buf_free) begin
            load = 1'b1;
          end else begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (buf_free) begin
          load = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (frame_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A load overrides the empty-on-read above so the output never drops between words.
    if (load) begin
      out_d   = word_d;
      avail_d = 1'b1;
      if (led_q != LAST_LED) begin
        state_d    = ST_FETCH;
        led_d      = led_q + NW'(1);
        iss_d      = '0;
        cap_d      = '0;
        led_base_d = led_base_q + STEP_A;
      end else begin
        state_d = ST_DRAIN;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      led_q      <= '0;
      iss_q      <= '0;
      cap_q      <= '0;
      led_base_q <= '0;
      out_q      <= '0;
      avail_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      led_q      <= led_d;
      iss_q      <= iss_d;
      cap_q      <= cap_d;
      led_base_q <= led_base_d;
      out_q      <= out_d;
      avail_q    <= avail_d;
    end
  end

  assign bitstream           = out_q;
  assign bitstream_available = avail_q;

endmodule
